// File: rtl/wts_pkg.sv
// Shared definitions for the wave table sound core.
// Holds the default datapath widths, the index-width helper and the
// round-toward-zero scaling function used by every gain stage.
package wts_pkg;

  localparam int unsigned WTS_SAMPLE_W = 8;
  localparam int unsigned WTS_ENV_W    = 4;
  localparam int unsigned WTS_VOL_W    = 4;
  localparam int unsigned WTS_CH_NUM   = 5;

  // Bits needed to index n entries, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

  // Divide a signed product by 2^shamt, rounding toward zero.
  // Arithmetic shift floors, so negative values with a nonzero remainder get +1.
  function automatic logic signed [31:0] scale_rtz(input logic signed [31:0] p,
                                                   input int unsigned        shamt);
    logic signed [31:0] q;
    logic        [31:0] mask;
    mask = (32'd1 << shamt) - 32'd1;
    q    = p >>> shamt;
    if (p[31] && ((32'(p) & mask) != 32'd0)) q = q + 32'sd1;
    return q;
  endfunction

endpackage

// File: rtl/wts_channel_volume_ramp_if.sv
// Slot and volume-control bundle of the channel volume ramp scaler.
// master: slot source / register writer; slave: the scaler itself.
interface wts_channel_volume_ramp_if
  import wts_pkg::*;
#(
  parameter int unsigned SAMPLE_W = WTS_SAMPLE_W,
  parameter int unsigned ENV_W    = WTS_ENV_W,
  parameter int unsigned VOL_W    = WTS_VOL_W,
  parameter int unsigned CH_W     = 3
);
  logic                       in_valid;
  logic [CH_W-1:0]            in_ch;
  logic signed [SAMPLE_W-1:0] in_sample;
  logic [ENV_W:0]             in_env;
  logic                       in_noise;
  logic                       vol_we;
  logic [CH_W-1:0]            vol_ch;
  logic [VOL_W-1:0]           vol_data;
  logic                       ramp_en;
  logic                       out_valid;
  logic [CH_W-1:0]            out_ch;
  logic signed [SAMPLE_W-1:0] out_sample;
  logic                       ramp_busy;

  modport master (
    output in_valid, in_ch, in_sample, in_env, in_noise,
    output vol_we, vol_ch, vol_data, ramp_en,
    input  out_valid, out_ch, out_sample, ramp_busy
  );

  modport slave (
    input  in_valid, in_ch, in_sample, in_env, in_noise,
    input  vol_we, vol_ch, vol_data, ramp_en,
    output out_valid, out_ch, out_sample, ramp_busy
  );
endinterface

// File: rtl/wts_volume_ramp_bank.sv
// Per-channel target/current volume registers with zipper-free ramping.
// Ports: clk, reset (sync, active-high); tick_i frame tick; ramp_en_i mode;
// we_i/wch_i/wdata_i target write; rd_ch_i/rd_vol_c_o combinational read;
// ramp_busy_o registered "any channel still ramping".
module wts_volume_ramp_bank
  import wts_pkg::*;
#(
  parameter int unsigned CH_NUM   = WTS_CH_NUM,
  parameter int unsigned CH_W     = 3,
  parameter int unsigned VOL_W    = WTS_VOL_W,
  parameter int unsigned RAMP_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             ramp_en_i,
  input  logic             we_i,
  input  logic [CH_W-1:0]  wch_i,
  input  logic [VOL_W-1:0] wdata_i,
  input  logic [CH_W-1:0]  rd_ch_i,
  output logic [VOL_W-1:0] rd_vol_c_o,
  output logic             ramp_busy_o
);
  localparam int unsigned CNT_W = clog2_min1(RAMP_DIV);

  logic [VOL_W-1:0] cur_vol_q [CH_NUM];
  logic [VOL_W-1:0] cur_vol_d [CH_NUM];
  logic [VOL_W-1:0] tgt_vol_q [CH_NUM];
  logic [VOL_W-1:0] tgt_vol_d [CH_NUM];
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             ramp_busy_q;
  logic             step_c;
  logic             busy_c;

  // Frame divider: a step fires on the tick that wraps the counter.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    step_c      = 1'b0;
    if (tick_i) begin
      if (frame_cnt_q == CNT_W'(RAMP_DIV - 1)) begin
        frame_cnt_d = '0;
        step_c      = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  // Step compares against the pre-write target; an immediate write overrides the step.
  always_comb begin
    cur_vol_d = cur_vol_q;
    tgt_vol_d = tgt_vol_q;
    busy_c    = 1'b0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      if (step_c && ramp_en_i) begin
        if (cur_vol_q[i] < tgt_vol_q[i])      cur_vol_d[i] = cur_vol_q[i] + VOL_W'(1);
        else if (cur_vol_q[i] > tgt_vol_q[i]) cur_vol_d[i] = cur_vol_q[i] - VOL_W'(1);
      end
      if (we_i && (wch_i == CH_W'(i))) begin
        tgt_vol_d[i] = wdata_i;
        if (!ramp_en_i) cur_vol_d[i] = wdata_i;
      end
      if (cur_vol_q[i] != tgt_vol_q[i]) busy_c = 1'b1;
    end
  end

  // Read port; out-of-range channels read as silence.
  always_comb begin
    rd_vol_c_o = '0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      if (rd_ch_i == CH_W'(i)) rd_vol_c_o = cur_vol_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(CH_NUM); i++) begin
        cur_vol_q[i] <= '0;
        tgt_vol_q[i] <= '0;
      end
      frame_cnt_q <= '0;
      ramp_busy_q <= 1'b0;
    end else begin
      cur_vol_q   <= cur_vol_d;
      tgt_vol_q   <= tgt_vol_d;
      frame_cnt_q <= frame_cnt_d;
      ramp_busy_q <= busy_c;
    end
  end

  assign ramp_busy_o = ramp_busy_q;
endmodule

// File: rtl/wts_channel_volume_ramp.sv
// Time-multiplexed channel scaler: envelope gate/scale, then ramped volume.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries the
// input slot, the volume write port, ramp_en and the output slot/ramp_busy.
// Three register stages, one slot per cycle, no stalls.
module wts_channel_volume_ramp
  import wts_pkg::*;
#(
  parameter int unsigned SAMPLE_W = WTS_SAMPLE_W,
  parameter int unsigned ENV_W    = WTS_ENV_W,
  parameter int unsigned VOL_W    = WTS_VOL_W,
  parameter int unsigned CH_NUM   = WTS_CH_NUM,
  parameter int unsigned RAMP_DIV = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  wts_channel_volume_ramp_if.slave   bus
);
  localparam int unsigned CH_W = clog2_min1(CH_NUM);
  localparam int unsigned P2_W = SAMPLE_W + ENV_W + 1;
  localparam int unsigned P3_W = SAMPLE_W + VOL_W + 1;

  logic                       s1_valid_q, s2_valid_q, out_valid_q;
  logic [CH_W-1:0]            s1_ch_q, s2_ch_q, out_ch_q;
  logic signed [SAMPLE_W-1:0] s1_sample_q, s2_sample_q, out_sample_q;
  logic [ENV_W:0]             s1_env_q;
  logic signed [SAMPLE_W-1:0] s2_sample_d, out_sample_d;
  logic signed [P2_W-1:0]     p2;
  logic signed [P3_W-1:0]     p3;
  logic [VOL_W-1:0]           rd_vol;
  logic                       tick_c;

  // Frame ends when the last channel's slot sits in S1.
  assign tick_c = s1_valid_q && (s1_ch_q == CH_W'(CH_NUM - 1));

  wts_volume_ramp_bank #(
    .CH_NUM   (CH_NUM),
    .CH_W     (CH_W),
    .VOL_W    (VOL_W),
    .RAMP_DIV (RAMP_DIV)
  ) u_bank (
    .clk         (clk),
    .reset       (reset),
    .tick_i      (tick_c),
    .ramp_en_i   (bus.ramp_en),
    .we_i        (bus.vol_we),
    .wch_i       (bus.vol_ch),
    .wdata_i     (bus.vol_data),
    .rd_ch_i     (s2_ch_q),
    .rd_vol_c_o  (rd_vol),
    .ramp_busy_o (bus.ramp_busy)
  );

  // Envelope stage: bypass passes the sample, otherwise scale by magnitude/2^ENV_W.
  always_comb begin
    s2_sample_d = s1_sample_q;
    p2 = $signed({{(ENV_W + 1){s1_sample_q[SAMPLE_W-1]}}, s1_sample_q}) *
         $signed({{(SAMPLE_W + 1){1'b0}}, s1_env_q[ENV_W-1:0]});
    if (!s1_env_q[ENV_W]) s2_sample_d = SAMPLE_W'(scale_rtz(32'(p2), ENV_W));
  end

  // Volume stage: invalid channels read volume 0 and so emit silence.
  always_comb begin
    p3 = $signed({{(VOL_W + 1){s2_sample_q[SAMPLE_W-1]}}, s2_sample_q}) *
         $signed({{(SAMPLE_W + 1){1'b0}}, rd_vol});
    out_sample_d = SAMPLE_W'(scale_rtz(32'(p3), VOL_W));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_ch_q      <= '0;
      s1_sample_q  <= '0;
      s1_env_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_ch_q      <= '0;
      s2_sample_q  <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_sample_q <= '0;
    end else begin
      s1_valid_q   <= bus.in_valid;
      s1_ch_q      <= bus.in_ch;
      s1_sample_q  <= bus.in_sample;
      s1_env_q     <= bus.in_noise ? bus.in_env : '0;
      s2_valid_q   <= s1_valid_q;
      s2_ch_q      <= s1_ch_q;
      s2_sample_q  <= s2_sample_d;
      out_valid_q  <= s2_valid_q;
      out_ch_q     <= s2_ch_q;
      out_sample_q <= out_sample_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.out_sample = out_sample_q;
endmodule

// File: tb/tb_wts_channel_volume_ramp.sv
// Directed bench for wts_channel_volume_ramp with a slot scoreboard and a
// behavioural volume model (RAMP_DIV = 2, five channels).
module tb_wts_channel_volume_ramp;
  localparam int SW  = 8;
  localparam int EW  = 4;
  localparam int VW  = 4;
  localparam int NCH = 5;
  localparam int CW  = 3;
  localparam int RD  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wts_channel_volume_ramp_if #(.SAMPLE_W(SW), .ENV_W(EW), .VOL_W(VW), .CH_W(CW)) bus ();

  wts_channel_volume_ramp #(
    .SAMPLE_W(SW), .ENV_W(EW), .VOL_W(VW), .CH_NUM(NCH), .RAMP_DIV(RD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          ch;
    int          val;
    int unsigned issued;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cur[NCH];
  int   tgt[NCH];
  int   fcnt;
  bit   ren;
  bit   coll_pending;
  int   coll_ch, coll_val;

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // SV integer division truncates toward zero.
  function automatic int rtz(input int p, input int sh);
    return p / (1 << sh);
  endfunction

  function automatic int expv(input int ch, input int sample, input int env, input bit noise);
    int e, s2;
    e  = noise ? env : 0;
    s2 = ((e & 16) != 0) ? sample : rtz(sample * (e & 15), EW);
    if (ch >= NCH) return 0;
    return rtz(s2 * cur[ch], VW);
  endfunction

  function automatic int model_busy();
    for (int i = 0; i < NCH; i++) if (cur[i] != tgt[i]) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin cur[i] = 0; tgt[i] = 0; end
    fcnt = 0;
  endtask

  // The last-channel slot's own S3 already sees the step it triggers.
  task automatic model_frame();
    if (fcnt == RD - 1) begin
      fcnt = 0;
      if (ren)
        for (int i = 0; i < NCH; i++) begin
          if (cur[i] < tgt[i]) cur[i]++;
          else if (cur[i] > tgt[i]) cur[i]--;
        end
    end else begin
      fcnt++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.in_valid = 1'b0;
      bus.vol_we   = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic slot(input int ch, input int sample, input int env, input bit noise);
    exp_t e;
    if (ch == NCH - 1) model_frame();
    bus.in_valid  = 1'b1;
    bus.in_ch     = CW'(ch);
    bus.in_sample = SW'(sample);
    bus.in_env    = 5'(env);
    bus.in_noise  = noise;
    bus.vol_we    = 1'b0;
    e.ch     = ch;
    e.val    = expv(ch, sample, env, noise);
    e.issued = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wr(input int ch, input int val);
    bus.in_valid = 1'b0;
    bus.vol_we   = 1'b1;
    bus.vol_ch   = CW'(ch);
    bus.vol_data = VW'(val);
    if (ch < NCH) begin
      tgt[ch] = val;
      if (!ren) cur[ch] = val;
    end
    @(negedge clk);
    bus.vol_we = 1'b0;
  endtask

  task automatic set_ramp(input bit v);
    bus.ramp_en = v;
    ren         = v;
  endtask

  // One round-robin frame of bypassed slots; optionally lands a write on the step edge.
  task automatic frame(input int sample);
    bit will_step;
    for (int c = 0; c < NCH - 1; c++) slot(c, sample, 16, 1'b1);
    will_step = (fcnt == RD - 1);
    slot(NCH - 1, sample, 16, 1'b1);
    if (coll_pending && will_step) begin
      wr(coll_ch, coll_val);
      coll_pending = 1'b0;
    end
  endtask

  // Output monitor: every output slot must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_out: out_valid=%b out_sample=%0d with no pending slot",
               bus.out_valid, bus.out_sample);
      end else begin
        e = sb.pop_front();
        check("out_ch", bus.out_ch, e.ch);
        check("out_sample", bus.out_sample, e.val);
        check("latency", int'(cyc - e.issued), 3);
      end
    end
  end

  initial begin
    int guard;
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_sample = '0;
    bus.in_env    = '0;
    bus.in_noise  = 1'b0;
    bus.vol_we    = 1'b0;
    bus.vol_ch    = '0;
    bus.vol_data  = '0;
    set_ramp(1'b0);
    coll_pending = 1'b0;
    model_reset();
    reset = 1'b1;
    idle(3);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_out_sample", bus.out_sample, 0);
    check("rst_ramp_busy", bus.ramp_busy, 0);
    reset = 1'b0;
    idle(1);

    // Envelope rounding at full immediate volume on ch0.
    wr(0, 15);
    idle(1);
    slot(0, -128, 15, 1'b1);
    slot(0, -1, 1, 1'b1);
    slot(0, 127, 15, 1'b1);
    idle(4);
    check("busy_after_imm", bus.ramp_busy, 0);

    // Bypass and noise gate.
    slot(0, -77, 16, 1'b1);
    slot(0, -77, 16, 1'b0);
    idle(4);

    // Ramp ch2 0 -> 8 while other channels hold.
    wr(1, 5);
    wr(3, 7);
    wr(4, 15);
    idle(2);
    set_ramp(1'b1);
    idle(1);
    wr(2, 8);
    idle(2);
    check("busy_ramp_start", bus.ramp_busy, 1);
    for (int f = 0; f < 16; f++) frame(127);
    idle(1);
    check("busy_last_step", bus.ramp_busy, 1);
    idle(1);
    check("busy_ramp_done", bus.ramp_busy, 0);
    frame(127);
    idle(4);

    // Ramp down from 12, retarget to 10 after three steps.
    set_ramp(1'b0);
    idle(1);
    wr(2, 12);
    idle(2);
    set_ramp(1'b1);
    idle(1);
    wr(2, 0);
    guard = 0;
    while (cur[2] != 9 && guard < 20) begin frame(100); guard++; end
    wr(2, 10);
    guard = 0;
    while (cur[2] != 10 && guard < 20) begin frame(100); guard++; end
    for (int f = 0; f < 3; f++) frame(100);
    idle(4);
    check("busy_retarget", bus.ramp_busy, model_busy());

    // Write landing on a step edge: that step follows the old target.
    wr(1, 9);
    coll_pending = 1'b1;
    coll_ch      = 1;
    coll_val     = 0;
    for (int f = 0; f < 8; f++) frame(-90);
    idle(4);

    // Immediate mode: mid-ramp channels hold; out-of-range write/slot.
    set_ramp(1'b0);
    idle(1);
    frame(120);
    idle(4);
    check("busy_held", bus.ramp_busy, model_busy());
    wr(4, 9);
    idle(1);
    slot(4, 127, 16, 1'b1);
    wr(6, 15);
    idle(2);
    frame(127);
    slot(7, 100, 16, 1'b1);
    idle(4);

    // Reset with a ramp running and slots in flight.
    set_ramp(1'b1);
    idle(1);
    wr(0, 3);
    slot(0, 100, 16, 1'b1);
    slot(1, 100, 16, 1'b1);
    reset = 1'b1;
    sb.delete();
    model_reset();
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_sample", bus.out_sample, 0);
    check("midrst_ramp_busy", bus.ramp_busy, 0);
    idle(1);
    reset = 1'b0;
    idle(1);
    slot(0, 127, 16, 1'b1);
    slot(0, -128, 15, 1'b1);
    idle(4);
    check("post_rst_busy", bus.ramp_busy, 0);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
